// File: rtl/mmio_input_port_pkg.sv
// Shared constants and read-address decode for the memory-mapped input port.
// The cycle timer at ADDRTIMER exists only when MMIO_CYCLE_TIMER_EN is defined.
package mmio_input_port_pkg;

    localparam int unsigned SW_W   = 10;
    localparam int unsigned KEY_W  = 4;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 16;

    localparam logic [ADDR_W-1:0] ADDRSW    = 10'h3F0;
    localparam logic [ADDR_W-1:0] ADDRKEY   = 10'h3F1;
    localparam logic [ADDR_W-1:0] ADDRKEYEV = 10'h3F2;
    localparam logic [ADDR_W-1:0] ADDRTIMER = 10'h3F3;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_SW,
        SEL_KEY,
        SEL_KEYEV,
        SEL_TIMER
    } rd_sel_e;

    function automatic rd_sel_e decode_addr(input logic [ADDR_W-1:0] addr);
        rd_sel_e sel;
        sel = SEL_NONE;
        case (addr)
            ADDRSW:    sel = SEL_SW;
            ADDRKEY:   sel = SEL_KEY;
            ADDRKEYEV: sel = SEL_KEYEV;
`ifdef MMIO_CYCLE_TIMER_EN
            ADDRTIMER: sel = SEL_TIMER;
`endif
            default:   sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mmio_input_port_key_debouncer.sv
// One push-button: 2-flop synchroniser, stability counter, debounced level
// and a single-cycle press pulse on the accepted 1->0 transition.
module key_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic I_CLOCK,
    input  logic I_LOCK,
    input  logic I_KEY,
    output logic O_Stable,
    output logic O_Press
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 sync_q1;
    logic                 sync_q2;
    logic                 stable_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 differ;
    logic                 expire;

    assign differ = sync_q2 ^ stable_q;
    assign expire = differ && (cnt_q == CNT_MAX);

    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            sync_q1  <= 1'b1;
            sync_q2  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
        end else begin
            sync_q1 <= I_KEY;
            sync_q2 <= sync_q1;
            if (!differ) begin
                cnt_q <= '0;
            end else if (expire) begin
                stable_q <= sync_q2;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign O_Stable = stable_q;
    // stable_q still 1 while expiring means the accepted change is a press
    assign O_Press  = expire & stable_q;

endmodule

// File: rtl/mmio_input_port.sv
// Memory-mapped input responder: switches, debounced keys, latched press events.
// Optional MMIO_CYCLE_TIMER_EN adds a free-running cycle counter at ADDRTIMER.
module mmio_input_port
    import mmio_input_port_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned CNT_WIDTH       = 16
) (
    input  logic              I_CLOCK,
    input  logic              I_LOCK,
    input  logic [SW_W-1:0]   I_SW,
    input  logic [KEY_W-1:0]  I_KEY,
    input  logic              I_RdEn,
    input  logic [ADDR_W-1:0] I_RdAddr,
    output logic [DATA_W-1:0] O_RdData,
    output logic              O_RdHit,
    output logic              O_KeyEvent
);

    logic [SW_W-1:0]  sw_q1;
    logic [SW_W-1:0]  sw_q2;
    logic [KEY_W-1:0] key_stable;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_ev_q;
    logic [KEY_W-1:0] key_ev_d;
    logic             ev_clr;
    rd_sel_e          rd_sel;

    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            sw_q1 <= '0;
            sw_q2 <= '0;
        end else begin
            sw_q1 <= I_SW;
            sw_q2 <= sw_q1;
        end
    end

    for (genvar g = 0; g < KEY_W; g++) begin : g_key
        key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_debouncer (
            .I_CLOCK (I_CLOCK),
            .I_LOCK  (I_LOCK),
            .I_KEY   (I_KEY[g]),
            .O_Stable(key_stable[g]),
            .O_Press (key_press[g])
        );
    end

    // Gating with I_LOCK keeps every output at zero while reset is held.
    assign rd_sel = (I_RdEn && I_LOCK) ? decode_addr(I_RdAddr) : SEL_NONE;
    assign ev_clr = (rd_sel == SEL_KEYEV);

    // A press on the clearing edge is OR-ed back in, so it is never lost.
    always_comb begin
        key_ev_d = key_ev_q;
        if (ev_clr) begin
            key_ev_d = key_ev_q & ~key_ev_q;
        end
        key_ev_d = key_ev_d | key_press;
    end

    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            key_ev_q <= '0;
        end else begin
            key_ev_q <= key_ev_d;
        end
    end

`ifdef MMIO_CYCLE_TIMER_EN
    logic [DATA_W-1:0] timer_q;

    always_ff @(negedge I_CLOCK or negedge I_LOCK) begin
        if (!I_LOCK) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_q + DATA_W'(1);
        end
    end
`endif

    always_comb begin
        O_RdData = '0;
        O_RdHit  = 1'b0;
        case (rd_sel)
            SEL_SW: begin
                O_RdData = {{(DATA_W-SW_W){1'b0}}, sw_q2};
                O_RdHit  = 1'b1;
            end
            SEL_KEY: begin
                O_RdData = {{(DATA_W-KEY_W){1'b0}}, ~key_stable};
                O_RdHit  = 1'b1;
            end
            SEL_KEYEV: begin
                O_RdData = {{(DATA_W-KEY_W){1'b0}}, key_ev_q};
                O_RdHit  = 1'b1;
            end
`ifdef MMIO_CYCLE_TIMER_EN
            SEL_TIMER: begin
                O_RdData = timer_q;
                O_RdHit  = 1'b1;
            end
`endif
            default: begin
                O_RdData = '0;
                O_RdHit  = 1'b0;
            end
        endcase
    end

    assign O_KeyEvent = |key_ev_q;

endmodule

// File: doc/mmio_input_port.md
Name: mmio_input_port

Overview:
Memory-mapped input responder for the data-memory path: the read-side counterpart to the LEDR/LEDG/HEX output registers driven by stores.
- Synchronises board switches and debounces push-buttons.
- Latches button press events.
- Answers load (LDW) lookups from the memory stage at dedicated I/O addresses. Hits are muxed over the DataMem read value.
- All state updates on negedge I_CLOCK, matching the pipeline stages.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles before a key change is accepted (1 ms at 50 MHz); legal range 2..65535
CNT_WIDTH, 16, width of each debounce counter; must hold DEBOUNCE_CYCLES-1

Ports:
I_CLOCK  input  1  pipeline clock; all registers update on its falling edge
I_LOCK  input  1  asynchronous active-low reset (0 = reset/hold, 1 = run)
I_SW  input  10  raw slide switches, asynchronous
I_KEY  input  4  raw push-buttons, asynchronous, active-low (0 = pressed)
I_RdEn  input  1  memory stage performing a valid LDW this cycle
I_RdAddr  input  10  MAR[9:0] of that load
O_RdData  output  16  read data, combinational from internal registers
O_RdHit  output  1  I_RdEn high and I_RdAddr is a decoded I/O address
O_KeyEvent  output  1  OR of all latched press-event bits

Behaviour:
Reset (I_LOCK=0, asynchronous, held while low):
- SW sync flops = 0; KEY sync flops = 4'b1111.
- Stable key state = 4'b1111; counters = 0; event bits = 0.
- O_RdData = 0, O_RdHit = 0, O_KeyEvent = 0.

Switch path:
- 2-flop synchroniser, no debounce.
- Value visible 2 negedges after the input changes.

Key path, per key, after the 2-flop synchroniser:
- sync == stable: counter <= 0.
- sync != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
- sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
- A glitch shorter than DEBOUNCE_CYCLES restarts the count and never changes the stable state.
- Stable 1->0 transition (press) sets that key's event bit. Release does not.

Address map (constants):
- 0x3F0 ADDRSW: data = {6'b0, SW_sync[9:0]}.
- 0x3F1 ADDRKEY: data = {12'b0, ~stable[3:0]} (1 = held).
- 0x3F2 ADDRKEYEV: data = {12'b0, event[3:0]}; read-to-clear.

Read side:
- O_RdHit = I_RdEn & (address decoded). O_RdData = mapped data when hit, else 0.
- Zero latency: valid in the same cycle as I_RdEn.
- Read-clear of ADDRKEYEV: on the negedge where I_RdEn and address = 0x3F2, event <= event & ~returned_bits | new_press.
- A press landing on the same edge as the clear survives, so no event is lost.
- Reads of other addresses have no side effects.
- I_RdEn low: no side effects, regardless of I_RdAddr.
- Reset mid-count clears all counters and events immediately.
- Unmapped address in 0x3F0..0x3FB: O_RdHit = 0, so DataMem data is used.

Optional Feature:
MMIO_CYCLE_TIMER_EN
- Defined: 16-bit free-running cycle counter.
  - Reset 0; increments every negedge while I_LOCK=1; wraps 0xFFFF->0x0000.
  - Readable at 0x3F3 ADDRTIMER, with O_RdHit = 1.
  - Read has no side effect.
- Undefined: no counter logic; 0x3F3 is unmapped (O_RdHit = 0).

Decomposition:
- global_def.h gains ADDRSW, ADDRKEY, ADDRKEYEV, ADDRTIMER (10-bit), alongside ADDRLEDR/ADDRLEDG/ADDRHEX.
- One natural sub-module: key_debouncer (synchroniser + counter + stable bit + press pulse), instantiated 4x with DEBOUNCE_CYCLES/CNT_WIDTH passed through.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Reset: I_LOCK=0 with I_SW=0x3FF, then release; read 0x3F0 on the 3rd negedge after release -> O_RdData=0x03FF, O_RdHit=1; all outputs 0 while I_LOCK=0.
- Debounce: KEY[2] low for 3 cycles, then high -> 0x3F1 reads 0x0000, no event. KEY[2] low for 10 cycles -> 0x3F1 = 0x0004 and 0x3F2 = 0x0004 (press at sync+4 cycles), O_KeyEvent=1.
- Read-to-clear: event = 0x0005, read 0x3F2 -> returns 0x0005; next read returns 0x0000, O_KeyEvent=0.
- Simultaneous: KEY[1] stable press lands on the same negedge as a 0x3F2 clear of event 0x0001 -> event afterwards = 0x0002.
- Decode: I_RdEn=0 at 0x3F2 -> no clear, O_RdHit=0. I_RdEn=1 at 0x3F5 -> O_RdHit=0, O_RdData=0.
- Timer (macro defined): 100 cycles after reset release, read 0x3F3 -> 0x0064. Forcing the counter to 0xFFFF -> 0x0000 next cycle. Macro undefined -> 0x3F3 O_RdHit=0.
